// File: rtl/traffic_monitor.sv
// Passive checker for a two-direction traffic light: tracks the legal phase sequence and latches the first violation.
// Duration checking is built only when TRAFFIC_MON_DURATION_CHK_EN is defined.
module traffic_monitor #(
  parameter int G_TICKS = 5,
  parameter int Y_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ns_g,
  input  logic       ns_y,
  input  logic       ns_r,
  input  logic       ew_g,
  input  logic       ew_y,
  input  logic       ew_r,
  output logic [1:0] phase,
  output logic       phase_vld,
  output logic       err,
  output logic [2:0] err_code,
  output logic [7:0] err_cnt,
  output logic [7:0] cycle_cnt
);

  typedef enum logic {SYNC, TRACK} state_t;
  state_t state, state_nxt;

  logic       ns_oh, ew_oh, leg, trk, chg;
  logic [1:0] lph, succ;
  logic       e1, e2, e3, e4;
  logic [2:0] code;

  assign ns_oh = $onehot({ns_g, ns_y, ns_r});
  assign ew_oh = $onehot({ew_g, ew_y, ew_r});

  // A phase is legal only when both directions show exactly the expected lamp
  always_comb begin
    leg = ns_oh & ew_oh;
    lph = 2'd0;
    if (ns_g & ew_r)      lph = 2'd0;
    else if (ns_y & ew_r) lph = 2'd1;
    else if (ns_r & ew_g) lph = 2'd2;
    else if (ns_r & ew_y) lph = 2'd3;
    else                  leg = 1'b0;
  end

  assign trk  = (state == TRACK);
  assign succ = phase + 2'd1;
  assign chg  = trk & leg & (lph != phase);

  assign e1 = ~ns_oh | ~ew_oh;
  assign e2 = ~ns_r & ~ew_r;
  assign e3 = trk & ((ns_r & ew_r) | (chg & (lph != succ)));

`ifdef TRAFFIC_MON_DURATION_CHK_EN
  logic [3:0] tick_cnt;
  logic       first;
  logic [3:0] lim;

  // Green phases are 0 and 2, yellow phases are 1 and 3
  assign lim = phase[0] ? 4'(Y_TICKS) : 4'(G_TICKS);
  assign e4  = trk & ~first &
               ((chg & (lph == succ) & (tick_cnt != lim)) |
                (~chg & tick & (tick_cnt >= lim)));

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      first    <= 1'b0;
    end else if (!trk) begin
      tick_cnt <= '0;
      if (leg) first <= 1'b1;
    end else if (chg) begin
      tick_cnt <= '0;
      first    <= 1'b0;
    end else if (tick && tick_cnt != 4'd15) begin
      tick_cnt <= tick_cnt + 4'd1;
    end
  end
`else
  logic unused_tick;
  assign unused_tick = tick ^ (G_TICKS == 0) ^ (Y_TICKS == 0);
  assign e4 = 1'b0;
`endif

  assign code = e1 ? 3'd1 : e2 ? 3'd2 : e3 ? 3'd3 : e4 ? 3'd4 : 3'd0;

  always_comb begin
    state_nxt = state;
    if (state == SYNC && leg) state_nxt = TRACK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SYNC;
      phase     <= 2'd0;
      phase_vld <= 1'b0;
      err       <= 1'b0;
      err_code  <= 3'd0;
      err_cnt   <= 8'd0;
      cycle_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      // Adopting any legal phase also covers resync after an order error
      if (leg) begin
        phase     <= lph;
        phase_vld <= 1'b1;
      end
      if (code != 3'd0 && !err) begin
        err      <= 1'b1;
        err_code <= code;
      end
      if (code != 3'd0 && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
      if (chg && phase == 2'd3 && lph == 2'd0) cycle_cnt <= cycle_cnt + 8'd1;
    end
  end

endmodule
